// File: rtl/ram_fifo_ctrl_if.sv
// Handshake and RAM-port bundle for ram_fifo_ctrl.
// almost_full/almost_empty exist only when FIFO_WATERMARK_EN is defined.
interface ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDRESS_SIZE = 3
) ();
    logic                    push;
    logic [DATA_WIDTH-1:0]   push_data;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   pop_data;
    logic                    pop_valid;
    logic                    full;
    logic                    empty;
    logic [ADDRESS_SIZE:0]   count;
    logic                    overflow;
    logic                    underflow;
`ifdef FIFO_WATERMARK_EN
    logic                    almost_full;
    logic                    almost_empty;
`endif
    logic                    ram_we;
    logic [ADDRESS_SIZE-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0]   ram_wr_data;
    logic                    ram_re;
    logic [ADDRESS_SIZE-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0]   ram_rd_data;

    // Controller side
    modport slave (
`ifdef FIFO_WATERMARK_EN
        output almost_full,
        output almost_empty,
`endif
        input  push,
        input  push_data,
        input  pop,
        input  ram_rd_data,
        output pop_data,
        output pop_valid,
        output full,
        output empty,
        output count,
        output overflow,
        output underflow,
        output ram_we,
        output ram_wr_addr,
        output ram_wr_data,
        output ram_re,
        output ram_rd_addr
    );

    // Producer/consumer and RAM side
    modport master (
`ifdef FIFO_WATERMARK_EN
        input  almost_full,
        input  almost_empty,
`endif
        output push,
        output push_data,
        output pop,
        output ram_rd_data,
        input  pop_data,
        input  pop_valid,
        input  full,
        input  empty,
        input  count,
        input  overflow,
        input  underflow,
        input  ram_we,
        input  ram_wr_addr,
        input  ram_wr_data,
        input  ram_re,
        input  ram_rd_addr
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM with wrap-flag pointers.
// Optional FIFO_WATERMARK_EN adds almost_full/almost_empty outputs.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_SIZE  = 3,
    parameter int ADDRESS_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    ram_fifo_ctrl_if.slave   bus
);
    localparam int PW = ADDRESS_SIZE + 1;
    localparam logic [PW-1:0] DEPTH_L = PW'(ADDRESS_DEPTH);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_pop_data;
    logic                  r_pop_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [PW-1:0]         w_wr_ptr_nxt;
    logic [PW-1:0]         w_rd_ptr_nxt;
    logic [DATA_WIDTH-1:0] w_pop_data_nxt;
    logic                  w_pop_valid_nxt;
    logic                  w_overflow_nxt;
    logic                  w_underflow_nxt;

    logic [PW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    // Occupancy is the modular pointer difference; with a power-of-two
    // depth, count == depth is exactly "low bits equal, wrap flags differ".
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_count == DEPTH_L);

    // Accept decisions look only at registered state, so a same-cycle
    // pop never frees room for a push and vice versa.
    assign w_push_ok = bus.push & ~w_full;
    assign w_pop_ok  = bus.pop  & ~w_empty;

    assign bus.ram_we      = w_push_ok;
    assign bus.ram_wr_addr = r_wr_ptr[ADDRESS_SIZE-1:0];
    assign bus.ram_wr_data = bus.push_data;
    assign bus.ram_re      = w_pop_ok;
    assign bus.ram_rd_addr = r_rd_ptr[ADDRESS_SIZE-1:0];

    assign bus.pop_data  = r_pop_data;
    assign bus.pop_valid = r_pop_valid;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.count     = w_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

`ifdef FIFO_WATERMARK_EN
    assign bus.almost_full  = (w_count >= DEPTH_L - PW'(1));
    assign bus.almost_empty = (w_count <= PW'(1));
`endif

    // Next-state: pointer advance, read-data capture and sticky errors
    always_comb begin
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_pop_data_nxt  = r_pop_data;
        w_pop_valid_nxt = 1'b0;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;

        if (w_push_ok) begin
            w_wr_ptr_nxt = r_wr_ptr + PW'(1);
        end else if (bus.push) begin
            w_overflow_nxt = 1'b1;
        end

        if (w_pop_ok) begin
            w_rd_ptr_nxt    = r_rd_ptr + PW'(1);
            w_pop_data_nxt  = bus.ram_rd_data;
            w_pop_valid_nxt = 1'b1;
        end else if (bus.pop) begin
            w_underflow_nxt = 1'b1;
        end
    end

    // State registers with asynchronous reset; RAM contents are untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_pop_data  <= w_pop_data_nxt;
            r_pop_valid <= w_pop_valid_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end
endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Synchronous FIFO controller that drives the write and read ports of an external dual-port RAM (DATA_WIDTH × ADDRESS_DEPTH). It turns push/pop requests into RAM write/read strobes and addresses, and tracks occupancy with wrap-around pointers. It returns read data with a one-cycle valid pulse. The block sits between a producer/consumer pair and the shared storage RAM, so the storage array stays a separate module.

## Interface
- DATA_WIDTH, 16, word width on push, pop and RAM data paths
- ADDRESS_SIZE, 3, RAM address width
- ADDRESS_DEPTH, 8, RAM words; must equal 2**ADDRESS_SIZE
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- push  input  1  write request
- push_data  input  DATA_WIDTH  word to enqueue
- pop  input  1  read request
- pop_data  output  DATA_WIDTH  dequeued word, registered
- pop_valid  output  1  one-cycle pulse: pop_data holds a new word
- full  output  1  count == ADDRESS_DEPTH
- empty  output  1  count == 0
- count  output  ADDRESS_SIZE+1  current occupancy, 0..ADDRESS_DEPTH
- overflow  output  1  sticky; set when a push is rejected
- underflow  output  1  sticky; set when a pop is rejected
- ram_we  output  1  RAM write strobe
- ram_wr_addr  output  ADDRESS_SIZE  RAM write address
- ram_wr_data  output  DATA_WIDTH  RAM write data
- ram_re  output  1  RAM read strobe
- ram_rd_addr  output  ADDRESS_SIZE  RAM read address
- ram_rd_data  input  DATA_WIDTH  RAM read data, valid in the same cycle as ram_re/ram_rd_addr

## Operation
- Pointers wr_ptr and rd_ptr are ADDRESS_SIZE+1 bits. The low bits form the RAM address. The MSB is the wrap flag.
- empty = (wr_ptr == rd_ptr). full = low bits equal and MSBs differ. count = wr_ptr − rd_ptr, modulo 2**(ADDRESS_SIZE+1).
- Push is accepted when push & ~full.
  - On acceptance, ram_we = 1, ram_wr_addr = wr_ptr[ADDRESS_SIZE-1:0], ram_wr_data = push_data.
  - wr_ptr increments on the clock edge.
- Pop is accepted when pop & ~empty.
  - On acceptance, ram_re = 1, ram_rd_addr = rd_ptr[ADDRESS_SIZE-1:0].
  - On the clock edge, pop_data <= ram_rd_data, pop_valid <= 1, and rd_ptr increments.
- ram_we, ram_re, ram_wr_addr, ram_wr_data and ram_rd_addr are combinational from the inputs and current pointers.
- Full/empty decisions use the registered state only:
  - push while full is rejected even if pop is accepted in the same cycle;
  - pop while empty is rejected even if push is accepted in the same cycle.
- A rejected push sets overflow and a rejected pop sets underflow. Both flags are cleared only by rst.
- Simultaneous accepted push and pop: both pointers advance and count is unchanged.
- Pointer wrap: low bits roll from ADDRESS_DEPTH−1 to 0 and the MSB toggles. No other special case exists.
- pop_data holds its last value when no pop is accepted.

## Timing
- Reset, asynchronous on rst assertion, sets:
  - wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0;
  - pop_data = 0, pop_valid = 0, overflow = underflow = 0.
- RAM contents are not cleared.
- Reset mid-operation discards all queued words. The first accepted push after release writes address 0.
- Push-to-pop latency: a word pushed in cycle N can be popped in cycle N+1, when empty deasserts. pop_valid is high in cycle N+2.
- Pop latency: pop accepted in cycle N gives pop_valid = 1 and pop_data valid in cycle N+1, for exactly one cycle per accepted pop.
- Back-to-back pops give one pop_valid per cycle.
- Flags and count update on the same edge as the pointers.

## Configuration
- FIFO_WATERMARK_EN defined: adds outputs almost_full and almost_empty, both registered-state derived.
  - almost_full = (count >= ADDRESS_DEPTH−1).
  - almost_empty = (count <= 1).
  - Both reset as 0 and 1 respectively.
- Not defined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset then push 0x1111..0x8888 on 8 consecutive cycles: ram_wr_addr sequence 0..7, count 8, full = 1 after the 8th edge, empty = 0.
- From full, push 0xDEAD with pop = 1:
  - pop accepted (pop_data = 0x1111 next cycle);
  - push rejected, ram_we = 0, overflow = 1;
  - count 7.
- Pop from empty while pushing 0xBEEF: pop rejected, underflow = 1. Next cycle pop returns 0xBEEF with pop_valid pulse.
- Wrap-around: push 12 and pop 12 in interleaved steady state (one push and one pop per cycle after one-word prefill). Data order preserved, addresses wrap 7→0, count stays 1, no sticky flags.
- Assert rst asynchronously mid-stream with count 5: all outputs return to reset values before the next clk edge. After release the next push writes address 0.
- With FIFO_WATERMARK_EN: count 6→7 raises almost_full; count 2→1 raises almost_empty; after reset almost_empty = 1.
